// File: rtl/c17_pkg.sv
// Shared constants and the reference c17 function for the balanced pipeline.
package c17_pkg;

  localparam int C17_LOGIC_LEVELS = 3;

  // Returns {N22, N23} for one bit-slice.
  function automatic logic [1:0] c17_ref(input logic n1, input logic n2, input logic n3,
                                         input logic n6, input logic n7);
    logic nand36;
    nand36 = ~(n3 & n6);
    return {(n1 & n3) | (n2 & nand36), nand36 & (n2 | n7)};
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: valid bit plus data, held on stall, valid cleared on flush.
module pipe_stage_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_hold,
  input  logic         i_clear,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      // Clear wins over hold so a flush empties even a stalled pipe.
      if (i_clear)     r_valid <= 1'b0;
      else if (!i_hold) r_valid <= i_valid;
      if (!i_hold)     r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/c17_pipe_balanced.sv
// Path-balanced, fully registered c17 over WIDTH slices with valid/ready,
// stall, flush, output retiming stages and a saturating output counter.
module c17_pipe_balanced
  import c17_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int EXTRA_STAGES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] N1,
  input  logic [WIDTH-1:0] N2,
  input  logic [WIDTH-1:0] N3,
  input  logic [WIDTH-1:0] N6,
  input  logic [WIDTH-1:0] N7,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] N22,
  output logic [WIDTH-1:0] N23,
  output logic             busy,
  output logic [CNT_W-1:0] out_count
);

  localparam int L = C17_LOGIC_LEVELS + EXTRA_STAGES;

  logic                 w_stall, w_accept, w_hs, w_busy;
  logic                 w_v1, w_v2;
  logic [4*WIDTH-1:0]   w_s1_q;
  logic [3*WIDTH-1:0]   w_s2_q;
  logic [WIDTH-1:0]     w_p, w_a, w_b, w_c, w_a2, w_d, w_e;
  logic                 w_tv [C17_LOGIC_LEVELS:L];
  logic [2*WIDTH-1:0]   w_td [C17_LOGIC_LEVELS:L];
  logic [CNT_W-1:0]     r_cnt;

  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall;
  assign w_accept = in_valid & in_ready;
  assign w_hs     = out_valid & out_ready;

  // Level 1: a, b, c plus N2 carried alongside as p.
  pipe_stage_reg #(.W(4*WIDTH)) u_s1 (
    .clk(clk), .rst_n(rst_n), .i_hold(w_stall), .i_clear(flush),
    .i_valid(w_accept), .i_data({N2, N1 & N3, N3 & N6, N2 | N7}),
    .o_valid(w_v1), .o_data(w_s1_q)
  );
  assign {w_p, w_a, w_b, w_c} = w_s1_q;

  pipe_stage_reg #(.W(3*WIDTH)) u_s2 (
    .clk(clk), .rst_n(rst_n), .i_hold(w_stall), .i_clear(flush),
    .i_valid(w_v1), .i_data({w_a, w_p & ~w_b, ~w_b & w_c}),
    .o_valid(w_v2), .o_data(w_s2_q)
  );
  assign {w_a2, w_d, w_e} = w_s2_q;

  pipe_stage_reg #(.W(2*WIDTH)) u_s3 (
    .clk(clk), .rst_n(rst_n), .i_hold(w_stall), .i_clear(flush),
    .i_valid(w_v2), .i_data({w_a2 | w_d, w_e}),
    .o_valid(w_tv[C17_LOGIC_LEVELS]), .o_data(w_td[C17_LOGIC_LEVELS])
  );

  for (genvar s = C17_LOGIC_LEVELS + 1; s <= L; s++) begin : g_retime
    pipe_stage_reg #(.W(2*WIDTH)) u_rt (
      .clk(clk), .rst_n(rst_n), .i_hold(w_stall), .i_clear(flush),
      .i_valid(w_tv[s-1]), .i_data(w_td[s-1]),
      .o_valid(w_tv[s]), .o_data(w_td[s])
    );
  end

  assign out_valid  = w_tv[L];
  assign {N22, N23} = w_td[L];

  always_comb begin
    w_busy = w_v1 | w_v2;
    for (int s = C17_LOGIC_LEVELS; s <= L; s++) w_busy = w_busy | w_tv[s];
  end
  assign busy = w_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_cnt <= '0;
    else if (w_hs && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
  end
  assign out_count = r_cnt;

endmodule

// File: tb/tb_c17_pipe_balanced.sv
// Randomised and directed bench for c17_pipe_balanced against a queue-based model.
module tb_c17_pipe_balanced;
  import c17_pkg::*;

  localparam int WIDTH = 8;
  localparam int EXTRA = 1;
  localparam int LAT   = 3 + EXTRA;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic [WIDTH-1:0] N1 = '0, N2 = '0, N3 = '0, N6 = '0, N7 = '0;
  logic in_ready, out_valid, busy;
  logic [WIDTH-1:0] N22, N23;
  logic [15:0] out_count;
  logic s_in_ready, s_out_valid, s_busy;
  logic [WIDTH-1:0] s_N22, s_N23;
  logic [2:0] s_out_count;

  int n_chk = 0, n_fail = 0;
  int m_cnt = 0, m_cnt3 = 0;
  logic [2*WIDTH-1:0] exp_q [$];

  always #5 clk = ~clk;

  c17_pipe_balanced #(.WIDTH(WIDTH), .EXTRA_STAGES(EXTRA), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .N1(N1), .N2(N2), .N3(N3), .N6(N6), .N7(N7), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .N22(N22), .N23(N23),
    .busy(busy), .out_count(out_count)
  );

  c17_pipe_balanced #(.WIDTH(WIDTH), .EXTRA_STAGES(EXTRA), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .N1(N1), .N2(N2), .N3(N3), .N6(N6), .N7(N7), .flush(flush),
    .out_valid(s_out_valid), .out_ready(out_ready), .N22(s_N22), .N23(s_N23),
    .busy(s_busy), .out_count(s_out_count)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [2*WIDTH-1:0] model(input logic [WIDTH-1:0] a, b, c, d, e);
    logic [WIDTH-1:0] r22, r23;
    logic [1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r = c17_ref(a[i], b[i], c[i], d[i], e[i]);
      r22[i] = r[1];
      r23[i] = r[0];
    end
    return {r22, r23};
  endfunction

  always @(negedge rst_n) begin
    exp_q.delete();
    m_cnt  = 0;
    m_cnt3 = 0;
  end

  // Scoreboard: items accepted but not yet consumed are exactly what the pipe holds.
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", busy, exp_q.size() != 0);
      check("in_ready", in_ready, !(out_valid && !out_ready));
      check("out_count", out_count, m_cnt);
      check("sat_count", s_out_count, m_cnt3);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", out_valid, 0);
        else check("result", {N22, N23}, exp_q.pop_front());
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt3 < 7) m_cnt3++;
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(model(N1, N2, N3, N6, N7));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand(input logic v);
    in_valid = v;
    N1 = WIDTH'($urandom); N2 = WIDTH'($urandom); N3 = WIDTH'($urandom);
    N6 = WIDTH'($urandom); N7 = WIDTH'($urandom);
  endtask

  task automatic drain();
    int t;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    t = 0;
    while (busy && t < 40) begin cyc(); t++; end
    check("drain_timeout", busy, 0);
  endtask

  initial begin
    int lat, run, best, cnt_saved;
    logic [2*WIDTH-1:0] frozen;
    logic [4:0] v;

    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_N22", N22, 0);
    check("rst_N23", N23, 0);
    check("rst_busy", busy, 0);
    check("rst_count", out_count, 0);
    check("rst_in_ready", in_ready, 1);
    #11 rst_n = 1'b1;

    // Single transaction, latency and value.
    cyc();
    in_valid = 1'b1; N1 = 8'hFF; N2 = 8'h0F; N3 = 8'hF0; N6 = 8'hCC; N7 = 8'h55;
    cyc();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin cyc(); lat++; end
    check("latency", lat, LAT);
    check("first_N22", N22, 8'hFF);
    check("first_N23", N23, 8'h1F);
    cyc();
    check("first_count", out_count, 1);

    // All 32 input combinations, back to back.
    run = 0; best = 0;
    for (int i = 0; i < 44; i++) begin
      if (i < 32) begin
        v = 5'(i);
        in_valid = 1'b1;
        N1 = {WIDTH{v[4]}}; N2 = {WIDTH{v[3]}}; N3 = {WIDTH{v[2]}};
        N6 = {WIDTH{v[1]}}; N7 = {WIDTH{v[0]}};
      end else in_valid = 1'b0;
      cyc();
      if (out_valid) begin run++; if (run > best) best = run; end
      else run = 0;
    end
    check("exhaustive_run", best, 32);

    // Stall with a full pipe.
    for (int i = 0; i < 6; i++) begin drive_rand(1'b1); cyc(); end
    drive_rand(1'b1);
    out_ready = 1'b0;
    #1;
    frozen = {N22, N23};
    check("stall_in_ready", in_ready, 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_frozen", {N22, N23}, frozen);
    end
    drain();

    // Flush with three in flight; input in the flush cycle is dropped.
    for (int i = 0; i < 3; i++) begin drive_rand(1'b1); cyc(); end
    drive_rand(1'b1);
    flush = 1'b1;
    cnt_saved = m_cnt;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_out_valid", out_valid, 0);
    check("flush_count", out_count, cnt_saved);
    drive_rand(1'b1);
    cyc();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin cyc(); lat++; end
    check("post_flush_latency", lat, LAT);
    drain();

    // Asynchronous reset with four in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin drive_rand(1'b1); cyc(); end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_N22", N22, 0);
    check("arst_N23", N23, 0);
    check("arst_count", out_count, 0);
    check("arst_busy", busy, 0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("arst_no_stale", out_valid, 0);
    end

    // Random traffic with backpressure and occasional flush.
    for (int i = 0; i < 300; i++) begin
      drive_rand(1'($urandom_range(0, 3) != 0));
      out_ready = 1'($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 19) == 0);
      cyc();
    end
    drain();

    // Guarantee enough handshakes for the 3-bit counter to saturate.
    for (int i = 0; i < 10; i++) begin drive_rand(1'b1); cyc(); end
    drain();
    check("sat_final", s_out_count, 7);
    check("sat_busy", s_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
